// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
//   state_t : arbiter FSM states (IDLE, REQ, WAIT)
//   owner_t : which CPU port owns the transaction in flight
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// port and the data port. One transaction is in flight at a time.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_if_req / i_if_addr     fetch request (held until o_if_rsp_valid)
//   o_if_rsp_valid/o_if_rdata  fetch completion pulse and data
//   i_dm_req, i_dm_addr, i_dm_we, i_dm_wdata, i_dm_wstrb  data request
//   o_dm_rsp_valid/o_dm_rdata  data completion pulse (read data or write ack)
//   o_mem_req_valid, i_mem_req_ready, o_mem_addr/we/wdata/wstrb  memory request
//   i_mem_rsp_valid, i_mem_rdata  memory response
//   o_busy                   FSM not in IDLE
//   o_err                    sticky: memory response seen outside WAIT
//   o_dbg_state              current FSM state, for observation
//
// Handshake: the memory request channel is valid/ready. Once o_mem_req_valid
// rises it stays high, with a constant payload, until the cycle in which
// i_mem_req_ready is sampled high; the request transfers on that edge. The
// memory answers with a single-cycle i_mem_rsp_valid no earlier than the
// following cycle, and never asserts ready and response in the same cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [XLEN-1:0]   i_if_addr,
  output logic              o_if_rsp_valid,
  output logic [XLEN-1:0]   o_if_rdata,
  input  logic              i_dm_req,
  input  logic [XLEN-1:0]   i_dm_addr,
  input  logic              i_dm_we,
  input  logic [XLEN-1:0]   i_dm_wdata,
  input  logic [XLEN/8-1:0] i_dm_wstrb,
  output logic              o_dm_rsp_valid,
  output logic [XLEN-1:0]   o_dm_rdata,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  input  logic              i_mem_rsp_valid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_busy,
  output logic              o_err,
  output logic [1:0]        o_dbg_state
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [SW-1:0]       streak_q, streak_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                we_q, we_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN/8-1:0]   wstrb_q, wstrb_d;
  logic                err_q, err_d;
  logic                grant_dm, grant_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      streak_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    // A response is only legal while waiting for one.
    err_d    = err_q | (i_mem_rsp_valid && (state_q != WAIT));
    grant_dm = 1'b0;
    grant_if = 1'b0;

    case (state_q)
      IDLE: begin
        // Data normally wins; fetch is forced once data has taken
        // MAX_DM_STREAK grants in a row while fetch was waiting.
        if (i_dm_req && !(i_if_req && (streak_q == STREAK_MAX))) begin
          grant_dm = 1'b1;
        end else if (i_if_req) begin
          grant_if = 1'b1;
        end

        if (grant_dm) begin
          state_d  = REQ;
          owner_d  = OWN_DM;
          addr_d   = i_dm_addr;
          we_d     = i_dm_we;
          wdata_d  = i_dm_wdata;
          wstrb_d  = i_dm_we ? i_dm_wstrb : '0;
          if (!i_if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d  = REQ;
          owner_d  = OWN_IF;
          addr_d   = i_if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          wstrb_d  = '0;
          streak_d = '0;
        end
      end
      REQ: begin
        if (i_mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (i_mem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion pulses go straight from the memory response to the owner.
  assign o_if_rsp_valid = (state_q == WAIT) && i_mem_rsp_valid && (owner_q == OWN_IF);
  assign o_dm_rsp_valid = (state_q == WAIT) && i_mem_rsp_valid && (owner_q == OWN_DM);
  assign o_if_rdata     = o_if_rsp_valid ? i_mem_rdata : '0;
  assign o_dm_rdata     = o_dm_rsp_valid ? i_mem_rdata : '0;

  assign o_mem_req_valid = (state_q == REQ);
  assign o_mem_addr      = addr_q;
  assign o_mem_we        = we_q;
  assign o_mem_wdata     = wdata_q;
  assign o_mem_wstrb     = wstrb_q;
  assign o_busy          = (state_q != IDLE);
  assign o_err           = err_q;
  assign o_dbg_state     = state_q;

endmodule
